hangman_guess_ctrl: RTL and testbench



---
 rtl/hangman_pkg.sv | 35 +++
 rtl/hangman_guess_ctrl_letter_match.sv | 24 ++
 rtl/hangman_guess_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_hangman_guess_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared types and constants for the hangman guess controller.
//   ctrl_state_t   : controller FSM states
//   guess_result_t : classification of one guessed byte
//   ASCII_A/Z      : bounds of the valid (uppercase) guess range
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package hangman_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GUESS,
      CHECK,
      SHOW,
      WIN,
      LOSE
   } ctrl_state_t;

   typedef enum logic [1:0] {
      INVALID,
      REPEAT,
      CORRECT,
      WRONG
   } guess_result_t;

   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_Z = 8'h5A;

   // True when the byte is an uppercase ASCII letter.
   function automatic logic is_upper(input logic [7:0] b);
      return (b >= ASCII_A) && (b <= ASCII_Z);
   endfunction

endpackage

// File: rtl/hangman_guess_ctrl_letter_match.sv
// -----------------------------------------------------------------------------
// letter_match
// Combinational compare of one byte against every position of the word.
//   letter : byte to look for
//   word   : WORD_LEN bytes, position 0 in the most significant byte
//   hit    : bit i set when position i equals letter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module letter_match #(
   parameter int WORD_LEN = 5
) (
   input  logic [7:0]            letter,
   input  logic [8*WORD_LEN-1:0] word,
   output logic [WORD_LEN-1:0]   hit
);

   genvar gi;
   generate
      for (gi = 0; gi < WORD_LEN; gi++) begin : g_pos
         assign hit[gi] = (word[8*WORD_LEN-1-8*gi -: 8] == letter);
      end
   endgenerate

endmodule

// File: rtl/hangman_guess_ctrl.sv
// -----------------------------------------------------------------------------
// hangman_guess_ctrl
// Scores UART guess bytes against a latched secret word, tracks revealed
// positions, wrong and repeated guesses, drives the status LEDs and the
// win/lose result, and pulses disp_update whenever the LCD rows must refresh.
//
// Ports:
//   clk, nRst          : clock, asynchronous active-low reset
//   msg, ready         : guess byte and its valid level (rising edge = guess)
//   set_word           : secret word, position 0 in the top byte
//   toggle_state       : start a game (IDLE only)
//   game_end           : return to IDLE from any other state
//   found_mask         : revealed positions
//   wrong_cnt          : wrong guesses so far
//   red/green/blue     : status LEDs (wrong / correct / repeat)
//   err_LED            : non-letter guess
//   win, lose          : game result levels
//   disp_update        : one-cycle LCD refresh request
//   busy               : guess in progress (CHECK or SHOW)
//
// Build option: define LOWERCASE_FOLD_EN to accept 'a'..'z' as 'A'..'Z'.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hangman_guess_ctrl
   import hangman_pkg::*;
#(
   parameter int WORD_LEN  = 5,
   parameter int MAX_WRONG = 6,
   parameter int LED_HOLD  = 1000
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic [7:0]            msg,
   input  logic                  ready,
   input  logic [8*WORD_LEN-1:0] set_word,
   input  logic                  toggle_state,
   input  logic                  game_end,
   output logic [WORD_LEN-1:0]   found_mask,
   output logic [2:0]            wrong_cnt,
   output logic                  red,
   output logic                  green,
   output logic                  blue,
   output logic                  err_LED,
   output logic                  win,
   output logic                  lose,
   output logic                  disp_update,
   output logic                  busy
);

   localparam int HOLD_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;

   ctrl_state_t           state_reg, state_next;
   logic [8*WORD_LEN-1:0] word_reg, word_next;
   logic [7:0]            guess_reg, guess_next;
   logic                  ready_q;
   logic [25:0]           used_reg, used_next;
   logic [WORD_LEN-1:0]   found_reg, found_next;
   logic [2:0]            wrong_reg, wrong_next;
   logic                  red_reg, red_next;
   logic                  green_reg, green_next;
   logic                  blue_reg, blue_next;
   logic                  err_reg, err_next;
   logic                  win_reg, win_next;
   logic                  lose_reg, lose_next;
   logic                  disp_reg, disp_next;
   logic                  busy_reg, busy_next;
   logic [HOLD_W-1:0]     hold_reg, hold_next;

   logic                  guess_evt;
   logic [7:0]            guess_fold;
   logic [4:0]            guess_idx;
   logic [WORD_LEN-1:0]   hit;
   guess_result_t         guess_res;

   // Only the rising edge of ready is a guess; a held level is one guess.
   assign guess_evt = ready && !ready_q;

   letter_match #(.WORD_LEN(WORD_LEN)) u_match (
      .letter (guess_fold),
      .word   (word_reg),
      .hit    (hit)
   );

   // Classification of the latched guess byte.
   always_comb begin
      guess_fold = guess_reg;
`ifdef LOWERCASE_FOLD_EN
      if (guess_reg >= 8'h61 && guess_reg <= 8'h7A)
         guess_fold = guess_reg - 8'h20;
`else
      // Lowercase stays outside A-Z and classifies as invalid.
`endif
      guess_idx = 5'(guess_fold - ASCII_A);
      if (!is_upper(guess_fold))
         guess_res = INVALID;
      else if (used_reg[guess_idx])
         guess_res = REPEAT;
      else if (|hit)
         guess_res = CORRECT;
      else
         guess_res = WRONG;
   end

   always_comb begin
      state_next = state_reg;
      word_next  = word_reg;
      guess_next = guess_reg;
      used_next  = used_reg;
      found_next = found_reg;
      wrong_next = wrong_reg;
      red_next   = red_reg;
      green_next = green_reg;
      blue_next  = blue_reg;
      err_next   = err_reg;
      win_next   = win_reg;
      lose_next  = lose_reg;
      disp_next  = 1'b0;
      hold_next  = hold_reg;

      case (state_reg)
         IDLE: begin
            if (toggle_state) begin
               word_next  = set_word;
               found_next = '0;
               wrong_next = '0;
               used_next  = '0;
               disp_next  = 1'b1;
               state_next = WAIT_GUESS;
            end
         end
         WAIT_GUESS: begin
            if (guess_evt) begin
               guess_next = msg;
               state_next = CHECK;
            end
         end
         CHECK: begin
            red_next   = 1'b0;
            green_next = 1'b0;
            blue_next  = 1'b0;
            err_next   = 1'b0;
            case (guess_res)
               INVALID: err_next = 1'b1;
               REPEAT:  blue_next = 1'b1;
               CORRECT: begin
                  found_next = found_reg | hit;
                  green_next = 1'b1;
               end
               default: begin
                  wrong_next = wrong_reg + 3'd1;
                  red_next   = 1'b1;
               end
            endcase
            if (guess_res != INVALID)
               used_next[guess_idx] = 1'b1;
            disp_next  = 1'b1;
            hold_next  = '0;
            state_next = SHOW;
         end
         SHOW: begin
            if (hold_reg == HOLD_W'(LED_HOLD - 1)) begin
               red_next   = 1'b0;
               green_next = 1'b0;
               blue_next  = 1'b0;
               err_next   = 1'b0;
               if (&found_reg) begin
                  win_next   = 1'b1;
                  green_next = 1'b1;
                  state_next = WIN;
               end else if (wrong_reg == 3'(MAX_WRONG)) begin
                  lose_next  = 1'b1;
                  red_next   = 1'b1;
                  state_next = LOSE;
               end else begin
                  state_next = WAIT_GUESS;
               end
            end else begin
               hold_next = hold_reg + HOLD_W'(1);
            end
         end
         WIN, LOSE: ;
         default: state_next = IDLE;
      endcase

      // game_end overrides everything; the word state is kept for display.
      if (game_end && state_reg != IDLE) begin
         state_next = IDLE;
         red_next   = 1'b0;
         green_next = 1'b0;
         blue_next  = 1'b0;
         err_next   = 1'b0;
         win_next   = 1'b0;
         lose_next  = 1'b0;
         disp_next  = 1'b0;
      end

      busy_next = (state_next == CHECK) || (state_next == SHOW);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_reg <= IDLE;
         word_reg  <= '0;
         guess_reg <= '0;
         ready_q   <= 1'b0;
         used_reg  <= '0;
         found_reg <= '0;
         wrong_reg <= '0;
         red_reg   <= 1'b0;
         green_reg <= 1'b0;
         blue_reg  <= 1'b0;
         err_reg   <= 1'b0;
         win_reg   <= 1'b0;
         lose_reg  <= 1'b0;
         disp_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         word_reg  <= word_next;
         guess_reg <= guess_next;
         ready_q   <= ready;
         used_reg  <= used_next;
         found_reg <= found_next;
         wrong_reg <= wrong_next;
         red_reg   <= red_next;
         green_reg <= green_next;
         blue_reg  <= blue_next;
         err_reg   <= err_next;
         win_reg   <= win_next;
         lose_reg  <= lose_next;
         disp_reg  <= disp_next;
         busy_reg  <= busy_next;
         hold_reg  <= hold_next;
      end
   end

   assign found_mask  = found_reg;
   assign wrong_cnt   = wrong_reg;
   assign red         = red_reg;
   assign green       = green_reg;
   assign blue        = blue_reg;
   assign err_LED     = err_reg;
   assign win         = win_reg;
   assign lose        = lose_reg;
   assign disp_update = disp_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_hangman_guess_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hangman_guess_ctrl
// Directed bench for hangman_guess_ctrl. Each start or guess pushes the
// expected display snapshot (found_mask, wrong_cnt, LEDs) and the cycle it
// must appear on into a queue; a monitor pops and compares on every
// disp_update pulse. Result states and reset values are checked directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hangman_guess_ctrl;

   localparam int HOLD = 16;

   typedef struct packed {
      logic [4:0] found;
      logic [2:0] wrong;
      logic       red;
      logic       green;
      logic       blue;
      logic       err;
   } obs_t;

   typedef struct {
      obs_t o;
      int   cyc;
   } exp_t;

   logic        tb_clk = 1'b0;
   logic        nRst = 1'b0;
   logic [7:0]  msg = 8'h00;
   logic        ready = 1'b0;
   logic [39:0] set_word = '0;
   logic        toggle_state = 1'b0;
   logic        game_end = 1'b0;
   logic [4:0]  found_mask;
   logic [2:0]  wrong_cnt;
   logic        red, green, blue, err_LED, win, lose, disp_update, busy;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_pop = 0;
   exp_t sb[$];

   hangman_guess_ctrl #(.WORD_LEN(5), .MAX_WRONG(6), .LED_HOLD(HOLD)) dut (
      .clk          (tb_clk),
      .nRst         (nRst),
      .msg          (msg),
      .ready        (ready),
      .set_word     (set_word),
      .toggle_state (toggle_state),
      .game_end     (game_end),
      .found_mask   (found_mask),
      .wrong_cnt    (wrong_cnt),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .err_LED      (err_LED),
      .win          (win),
      .lose         (lose),
      .disp_update  (disp_update),
      .busy         (busy)
   );

   always #5 tb_clk = ~tb_clk;
   always @(posedge tb_clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Scoreboard monitor: every refresh pulse must match the oldest expectation.
   always @(negedge tb_clk) begin
      if (nRst && disp_update) begin
         obs_t act;
         act = '{found_mask, wrong_cnt, red, green, blue, err_LED};
         n_pop++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL disp#%0d: unexpected disp_update at cycle %0d obs=%0h", n_pop, cyc, act);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_checks += 2;
            if (act !== e.o) begin
               n_fail++;
               $display("FAIL disp#%0d: obs %0h expected %0h", n_pop, act, e.o);
            end
            if (cyc != e.cyc) begin
               n_fail++;
               $display("FAIL disp#%0d latency: cycle %0d expected %0d", n_pop, cyc, e.cyc);
            end
            $display("disp#%0d cyc=%0d found=%b wrong=%0d rgbe=%b%b%b%b", n_pop, cyc,
                     found_mask, wrong_cnt, red, green, blue, err_LED);
         end
      end
   end

   function automatic obs_t mk(input logic [4:0] f, input logic [2:0] w, input logic [3:0] rgbe);
      return '{f, w, rgbe[3], rgbe[2], rgbe[1], rgbe[0]};
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge tb_clk);
      while (busy && n < 200) begin
         @(negedge tb_clk);
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: busy still high after 200 cycles", name);
      end
   endtask

   task automatic start_game(input logic [39:0] w);
      exp_t e;
      @(negedge tb_clk);
      set_word = w;
      toggle_state = 1'b1;
      e.o = mk(5'b0, 3'd0, 4'b0000);
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge tb_clk);
      toggle_state = 1'b0;
   endtask

   // Issue one guess; rgbe = {red, green, blue, err_LED} expected.
   task automatic guess(input logic [7:0] ch, input int hold_cyc, input logic [4:0] f,
                        input logic [2:0] w, input logic [3:0] rgbe,
                        input bit wait_done, input bit chk_clear);
      exp_t e;
      @(negedge tb_clk);
      msg = ch;
      ready = 1'b1;
      e.o = mk(f, w, rgbe);
      e.cyc = cyc + 2;
      sb.push_back(e);
      repeat (hold_cyc) @(negedge tb_clk);
      ready = 1'b0;
      if (wait_done) begin
         wait_idle("guess_done");
         if (chk_clear) chk("leds_clear", {28'b0, red, green, blue, err_LED}, 32'h0);
      end
   endtask

   // A guess edge that must be ignored (nothing pushed).
   task automatic pulse_ready(input logic [7:0] ch);
      @(negedge tb_clk);
      msg = ch;
      ready = 1'b1;
      @(negedge tb_clk);
      ready = 1'b0;
   endtask

   task automatic pulse_game_end();
      @(negedge tb_clk);
      game_end = 1'b1;
      @(negedge tb_clk);
      game_end = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge tb_clk);
      chk("reset_outputs", {17'b0, found_mask, wrong_cnt, red, green, blue, err_LED,
                            win, lose, disp_update, busy}, 32'h0);
      nRst = 1'b1;
      // Guess in IDLE is dropped
      pulse_ready("A");
      repeat (3) @(negedge tb_clk);
      chk("idle_guess_busy", {31'b0, busy}, 32'h0);

      // Game 1: MOORE; set_word changes after start are ignored
      start_game("MOORE");
      set_word = "ZZZZZ";
      wait_idle("start1");
      guess("O", 1, 5'b00110, 3'd0, 4'b0100, 1, 1);
      guess("P", 1, 5'b00110, 3'd1, 4'b1000, 1, 1);
      guess("M", 1, 5'b00111, 3'd1, 4'b0100, 1, 1);
      guess("M", 1, 5'b00111, 3'd1, 4'b0010, 1, 1);
      guess("R", 1, 5'b01111, 3'd1, 4'b0100, 1, 1);
      guess("E", 1, 5'b11111, 3'd1, 4'b0100, 1, 0);
      chk("win_state", {26'b0, win, lose, red, green, blue, err_LED}, 32'b10_0100);
      pulse_game_end();
      chk("after_end", {25'b0, win, lose, red, green, blue, err_LED, busy}, 32'h0);
      chk("found_hold", {27'b0, found_mask}, 32'b11111);

      // Game 2: YUMMY, invalid byte then six wrong letters
      start_game("YUMMY");
      wait_idle("start2");
      guess(8'h31, 1, 5'b0, 3'd0, 4'b0001, 1, 1);
      guess("I", 1, 5'b0, 3'd1, 4'b1000, 0, 0);
      repeat (3) @(negedge tb_clk);
      pulse_ready("U");               // during SHOW: dropped
      wait_idle("show_drop");
      chk("show_drop_found", {27'b0, found_mask}, 32'h0);
      guess("L", 1, 5'b0, 3'd2, 4'b1000, 1, 1);
      guess("K", 1, 5'b0, 3'd3, 4'b1000, 1, 1);
      guess("N", 1, 5'b0, 3'd4, 4'b1000, 1, 1);
      guess("J", 1, 5'b0, 3'd5, 4'b1000, 1, 1);
      guess("F", 1, 5'b0, 3'd6, 4'b1000, 1, 0);
      chk("lose_state", {26'b0, win, lose, red, green, blue, err_LED}, 32'b01_1000);
      pulse_ready("Y");               // after loss: ignored
      repeat (4) @(negedge tb_clk);
      chk("lose_hold_wrong", {29'b0, wrong_cnt}, 32'd6);
      chk("lose_hold_found", {27'b0, found_mask}, 32'h0);
      pulse_game_end();
      chk("after_end2", {25'b0, win, lose, red, green, blue, err_LED, busy}, 32'h0);

      // Game 3: APPLE, lowercase, held ready, then reset mid-game
      start_game("APPLE");
      wait_idle("start3");
`ifdef LOWERCASE_FOLD_EN
      guess("a", 1, 5'b00001, 3'd0, 4'b0100, 1, 1);
      guess("P", 10, 5'b00111, 3'd0, 4'b0100, 1, 1);
`else
      guess("a", 1, 5'b00000, 3'd0, 4'b0001, 1, 1);
      guess("P", 10, 5'b00110, 3'd0, 4'b0100, 1, 1);
`endif
      @(negedge tb_clk);
      nRst = 1'b0;
      #1;
      chk("midgame_reset", {17'b0, found_mask, wrong_cnt, red, green, blue, err_LED,
                            win, lose, disp_update, busy}, 32'h0);
      repeat (2) @(negedge tb_clk);
      nRst = 1'b1;
      pulse_ready("L");               // state IDLE: dropped
      repeat (3) @(negedge tb_clk);
      chk("post_reset_busy", {31'b0, busy}, 32'h0);
      start_game("HELLO");
      wait_idle("start4");
      guess("L", 1, 5'b01100, 3'd0, 4'b0100, 1, 1);

      repeat (5) @(negedge tb_clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
